// File: rtl/mask_bram_reader_if.sv
// Mask read-back bus: BRAM read port plus downstream FIFO write port.
// The master drives the address and the FIFO write; the slave returns read data and full.
interface mask_bram_reader_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [7:0]        bram_rd_data;
    logic              out_wr_en;
    logic [7:0]        out_din;
    logic              out_full;

    modport master (
        output bram_rd_addr,
        output out_wr_en,
        output out_din,
        input  bram_rd_data,
        input  out_full
    );

    modport slave (
        input  bram_rd_addr,
        input  out_wr_en,
        input  out_din,
        output bram_rd_data,
        output out_full
    );
endinterface

// File: rtl/mask_bram_reader.sv
// Streams the mask BRAM out in raster order into a FIFO, one pixel per clock,
// hiding the BRAM read latency behind a 2-entry skid buffer.
module mask_bram_reader #(
    parameter int unsigned WIDTH      = 640,
    parameter int unsigned HEIGHT     = 480,
    parameter int unsigned IMAGE_SIZE = WIDTH * HEIGHT
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    mask_bram_reader_if.master bus
);
    localparam int unsigned ADDR_W = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
    localparam int unsigned XW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(WIDTH);
    localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              inflight_q, inflight_d;
    logic [1:0]        occ_q, occ_d;
    logic [7:0]        head_q, head_d;
    logic [7:0]        tail_q, tail_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic              last_pix;
    logic              done;
    logic [XW-1:0]     x_nxt;
    logic [YW-1:0]     y_nxt;

    assign pop      = (occ_q != 2'd0) && !bus.out_full;
    assign push     = inflight_q;
    // Count what the buffer will hold once the read in flight lands, net of this clock's pop.
    assign issue    = (state_q == S_READ) &&
                      (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
    assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
    assign done     = (state_q == S_DRAIN) && !inflight_q && (occ_q == 2'd1) && pop;

    always_comb begin
        x_nxt = x_q + XW'(1);
        y_nxt = y_q;
        if (x_q == X_LAST) begin
            x_nxt = '0;
            y_nxt = y_q + YW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        inflight_d = issue;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_READ;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (last_pix) begin
                        state_d = S_DRAIN;
                    end else begin
                        x_d    = x_nxt;
                        y_d    = y_nxt;
                        addr_d = ADDR_W'(y_nxt) * W_A + ADDR_W'(x_nxt);
                    end
                end
            end
            S_DRAIN: begin
                if (done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Head always holds the oldest pixel; a simultaneous push/pop shifts tail into head.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (push && !pop) begin
            occ_d = occ_q + 2'd1;
            if (occ_q == 2'd0) head_d = bus.bram_rd_data;
            else               tail_d = bus.bram_rd_data;
        end else if (pop && !push) begin
            occ_d  = occ_q - 2'd1;
            head_d = tail_q;
        end else if (pop && push) begin
            if (occ_q == 2'd1) begin
                head_d = bus.bram_rd_data;
            end else begin
                head_d = tail_q;
                tail_d = bus.bram_rd_data;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    skid_no_overflow: assert property (@(posedge clock_i) disable iff (reset_i)
        !(push && !pop && (occ_q == 2'd2)));

    assign bus.bram_rd_addr = addr_q;
    assign bus.out_wr_en    = pop;
    assign bus.out_din      = head_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = done;
endmodule

// File: tb/tb_mask_bram_reader.sv
// Randomized self-checking bench for mask_bram_reader on a 4x3 frame with a
// preloaded BRAM model; every FIFO write is compared against the raster-order pixel list.
module tb_mask_bram_reader;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned N  = W * H;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:15];

    mask_bram_reader_if #(.ADDR_W(AW)) bus_if ();

    mask_bram_reader #(.WIDTH(W), .HEIGHT(H), .IMAGE_SIZE(N)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .start_i (start),
        .busy_o  (busy),
        .done_o  (done),
        .bus     (bus_if.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus_if.bram_rd_data <= mem[bus_if.bram_rd_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode: 0 free run, 1 stall 5 clocks after the 4th write, 2 toggle full, 3 random full
    task automatic run_frame(input int mode, input bit mid_start, input int reset_after,
                             output int first_lat, output int done_cyc);
        int writes = 0;
        int dones = 0;
        int stall_left = 0;
        bit stalled = 0;
        bit finished = 0;
        int addr_changes = 0;
        logic [AW-1:0] prev_addr = '0;
        bit toggle = 0;
        first_lat = -1;
        done_cyc = -1;
        @(negedge clk);
        bus_if.out_full = 1'b0;
        start = 1'b1;
        #1 chk("idle_before_start", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = mid_start && (cyc == 6);
            case (mode)
                1: begin
                    if (writes == 4 && !stalled) begin
                        stalled = 1;
                        stall_left = 5;
                        addr_changes = 0;
                        prev_addr = bus_if.bram_rd_addr;
                    end
                    bus_if.out_full = (stall_left > 0);
                end
                2: begin
                    toggle = ~toggle;
                    bus_if.out_full = toggle;
                end
                3: bus_if.out_full = ($urandom_range(0, 2) == 0);
                default: bus_if.out_full = 1'b0;
            endcase
            #1;
            if (mode == 1 && stall_left > 0) begin
                chk("no_write_in_stall", {31'd0, bus_if.out_wr_en}, 32'd0);
                if (bus_if.bram_rd_addr != prev_addr) addr_changes++;
                prev_addr = bus_if.bram_rd_addr;
                stall_left--;
                if (stall_left == 0) chk("stall_extra_issues_le2", {31'd0, addr_changes <= 2}, 32'd1);
            end
            chk("busy_in_frame", {31'd0, busy}, 32'd1);
            if (bus_if.out_full) chk("no_write_when_full", {31'd0, bus_if.out_wr_en}, 32'd0);
            if (bus_if.out_wr_en) begin
                if (first_lat < 0) first_lat = cyc;
                chk("pixel", {24'd0, bus_if.out_din}, {24'd0, 8'hA0 + 8'(writes)});
                writes++;
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                chk("done_with_last_write", {31'd0, bus_if.out_wr_en && (writes == int'(N))}, 32'd1);
                finished = 1;
            end
            if (reset_after > 0 && writes == reset_after) begin
                rst = 1'b1;
                #1;
                chk("reset_wr_en", {31'd0, bus_if.out_wr_en}, 32'd0);
                chk("reset_busy", {31'd0, busy}, 32'd0);
                chk("reset_addr", {28'd0, bus_if.bram_rd_addr}, 32'd0);
                @(negedge clk);
                chk("reset_hold_wr_en", {31'd0, bus_if.out_wr_en}, 32'd0);
                rst = 1'b0;
                return;
            end
            if (finished) break;
        end
        start = 1'b0;
        chk("frame_completed", {31'd0, finished}, 32'd1);
        chk("write_count", writes, N);
        chk("done_count", dones, 1);
    endtask

    initial begin
        int lat, dc;
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        rst = 1'b1;
        start = 1'b0;
        bus_if.out_full = 1'b0;
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_wr_en", {31'd0, bus_if.out_wr_en}, 32'd0);
        chk("rst_din", {24'd0, bus_if.out_din}, 32'd0);
        chk("rst_addr", {28'd0, bus_if.bram_rd_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // done lands on the edge IMAGE_SIZE+2 after the start-sampling edge
        run_frame(0, 0, 0, lat, dc);
        chk("free_first_latency", lat, 3);
        chk("free_done_cycle", dc, N + 2);
        run_frame(0, 0, 0, lat, dc);
        chk("b2b_first_latency", lat, 3);
        chk("b2b_done_cycle", dc, N + 2);

        run_frame(1, 0, 0, lat, dc);
        run_frame(2, 0, 0, lat, dc);
        run_frame(0, 1, 0, lat, dc);
        chk("midstart_done_cycle", dc, N + 2);

        run_frame(0, 0, 6, lat, dc);
        run_frame(0, 0, 0, lat, dc);
        chk("post_reset_first_latency", lat, 3);

        for (int r = 0; r < 4; r++) run_frame(3, r[0], 0, lat, dc);

        @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
